rr_onehot_arbiter: RTL
======================

// Module: rr_onehot_arbiter
// PURPOSE
//   Round-robin arbiter that turns N raw request lines into a registered
//   one-hot grant vector. It sits directly upstream of the one-hot-to-binary
//   encoder, which consumes gnt. The grant vector is guaranteed all-zero or
//   exactly one-hot. Each grant is held until it is released, times out, or
//   the winner withdraws its request.
// PARAMETERS
//   N         8   number of requesters; width of req and gnt
//   MAX_HOLD  16  max cycles a grant may stay asserted before forced release (>=1)
// PORTS
//   clk      in   1  single clock; all state updates on its rising edge
//   rst_n    in   1  asynchronous, active-low reset
//   req      in   N  level requests; bit i = requester i
//   done     in   1  one-cycle release pulse from the current owner
//   gnt      out  N  registered one-hot grant, or all-zero
//   busy     out  1  high while in GRANT (equals |gnt)
//   timeout  out  1  one-cycle pulse marking a forced release
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - gnt=0, busy=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0.
//     - Outputs go low immediately, without waiting for a clock edge.
//   State machine: IDLE, GRANT. The state register is internal.
//   IDLE
//     - If |req=0: remain in IDLE, gnt=0.
//     - If |req=1: at the edge, select the first set req bit in circular order
//       ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//     - Load gnt with that bit, set hold_cnt=0, go to GRANT.
//     - Latency: req sampled at edge k, gnt visible after edge k.
//     - done is ignored in IDLE.
//   GRANT
//     - gnt is held constant. hold_cnt increments each cycle.
//     - Release condition at an edge (first match wins):
//       a) done=1                        -> normal release, timeout stays 0
//       b) req[winner]=0                 -> withdraw release, timeout stays 0
//       c) hold_cnt==MAX_HOLD-1          -> forced release, timeout=1 for 1 cycle
//     - On any release: gnt=0, busy=0, ptr=(winner+1) mod N, go to IDLE.
//     - Result: gnt is high for at most MAX_HOLD cycles.
//     - Result: at least one all-zero gnt cycle separates consecutive grants.
//       The downstream encoder therefore never sees a gnt-to-gnt switch.
//     - Requests from other requesters while in GRANT are not registered.
//       They are re-evaluated in IDLE.
//   Arithmetic
//     - ptr is $clog2(N) bits; wrap from N-1 to 0 explicitly (N need not be
//       a power of 2).
//     - hold_cnt is $clog2(MAX_HOLD+1) bits and never overflows.
//   Invariants (assert in the bench)
//     - $onehot0(gnt) every cycle.
//     - busy == |gnt.
//     - timeout implies gnt==0.
// TESTING
//   1. Reset, then req=8'b1000_0001 -> gnt=8'b0000_0001 after 1 edge; pulse
//      done -> gnt=0 for 1 cycle, then gnt=8'b1000_0000.
//   2. req=8'hFF held, done pulsed in each grant cycle -> grant order 0,1,...,7,0
//      with a zero cycle between each grant.
//   3. req=8'b0000_0100 held, no done -> gnt high exactly 16 cycles; timeout
//      pulses 1 cycle with gnt=0; ptr=3, wraps around and regrants bit 2.
//   4. Winner 3 drops req[3] mid-grant while req[5]=1 -> gnt=0 next cycle,
//      timeout=0, then gnt=8'b0010_0000.
//   5. rst_n low mid-GRANT (asynchronous, between edges) -> gnt/busy=0
//      immediately; after release, req=8'hFF -> gnt=8'b0000_0001 (ptr reset).
//   6. done pulses and req toggles with no request active in IDLE, then req=0
//      -> gnt stays 0, busy=0, timeout=0 throughout.

Source files
------------

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: round-robin arbiter producing a registered one-hot (or zero) grant held until release or timeout
module rr_onehot_arbiter #(
  parameter int N = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt,
  output logic         busy,
  output logic         timeout
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_d;
  logic [N-1:0] gnt_d;
  logic [PW-1:0] ptr, ptr_d, win, win_d, sel;
  logic [HW-1:0] hold_cnt, hold_d;
  logic timeout_d;
  // Scan downward so the lowest circular offset from ptr overwrites last and wins.
  always_comb begin
    sel = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) sel = PW'((int'(ptr) + k) % N);
  end
  always_comb begin
    state_d = state;
    gnt_d = gnt;
    ptr_d = ptr;
    win_d = win;
    hold_d = hold_cnt;
    timeout_d = 1'b0;
    if (state == IDLE) begin
      if (|req) begin
        state_d = GRANT;
        win_d = sel;
        gnt_d = {{(N-1){1'b0}}, 1'b1} << sel;
        hold_d = '0;
      end
    end else if (done || !req[win] || hold_cnt == HW'(MAX_HOLD - 1)) begin
      state_d = IDLE;
      gnt_d = '0;
      hold_d = '0;
      timeout_d = !done && req[win];
      ptr_d = (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end else begin
      hold_d = hold_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      ptr <= '0;
      win <= '0;
      hold_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_d;
      gnt <= gnt_d;
      ptr <= ptr_d;
      win <= win_d;
      hold_cnt <= hold_d;
      timeout <= timeout_d;
    end
  end
  assign busy = |gnt;
endmodule
